// File: rtl/coin_accumulator.sv
// Coin-operated credit accumulator: debounces four coin buttons, queues coin
// events, and arbitrates coin deposits against purchase requests on one total.
module coin_accumulator #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MONEY_MAX       = 255
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic [3:0] BTN,
    input  logic       buy_req,
    input  logic [7:0] price,
    output logic [7:0] total_money,
    output logic       coin_ok,
    output logic       coin_reject,
    output logic       buy_ok,
    output logic       buy_fail
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0] MAX9 = 9'(MONEY_MAX);

    typedef enum logic [1:0] {
        IDLE,
        COIN,
        BUY
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    deb_q, deb_d;
    logic [3:0]    deb_prev_q, deb_prev_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    pend_q, pend_d;
    logic          buy_pend_q, buy_pend_d;
    logic [7:0]    total_q, total_d;
    logic          coin_ok_q, coin_ok_d;
    logic          coin_reject_q, coin_reject_d;
    logic          buy_ok_q, buy_ok_d;
    logic          buy_fail_q, buy_fail_d;

    logic [3:0]    rise;
    logic [3:0]    sel;
    logic [7:0]    coin_val;
    logic [8:0]    sum9;

    // Synchronizers and per-button debounce counters
    always_comb begin
        sync1_d    = BTN;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    // Highest-value pending coin is serviced first
    always_comb begin
        sel      = 4'b0000;
        coin_val = 8'd0;
        if (pend_q[3]) begin
            sel      = 4'b1000;
            coin_val = 8'd100;
        end else if (pend_q[2]) begin
            sel      = 4'b0100;
            coin_val = 8'd50;
        end else if (pend_q[1]) begin
            sel      = 4'b0010;
            coin_val = 8'd10;
        end else if (pend_q[0]) begin
            sel      = 4'b0001;
            coin_val = 8'd5;
        end
    end

    assign sum9 = {1'b0, total_q} + {1'b0, coin_val};

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q | rise;
        buy_pend_d    = buy_pend_q;
        total_d       = total_q;
        coin_ok_d     = 1'b0;
        coin_reject_d = 1'b0;
        buy_ok_d      = 1'b0;
        buy_fail_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // A purchase request outranks any queued coins
                if (buy_req || buy_pend_q) begin
                    state_d    = BUY;
                    buy_pend_d = 1'b0;
                end else if (|pend_q) begin
                    state_d = COIN;
                end
            end
            COIN: begin
                state_d = IDLE;
                if (buy_req) buy_pend_d = 1'b1;
                if (|sel) begin
                    pend_d = (pend_q & ~sel) | rise;
                    if (sum9 <= MAX9) begin
                        total_d   = sum9[7:0];
                        coin_ok_d = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            BUY: begin
                state_d = IDLE;
                if (buy_req) buy_pend_d = 1'b1;
                if (price != 8'd0 && total_q >= price) begin
                    total_d  = total_q - price;
                    buy_ok_d = 1'b1;
                end else begin
                    buy_fail_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q       <= IDLE;
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_prev_q    <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            pend_q        <= '0;
            buy_pend_q    <= 1'b0;
            total_q       <= '0;
            coin_ok_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            buy_ok_q      <= 1'b0;
            buy_fail_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_prev_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            buy_pend_q    <= buy_pend_d;
            total_q       <= total_d;
            coin_ok_q     <= coin_ok_d;
            coin_reject_q <= coin_reject_d;
            buy_ok_q      <= buy_ok_d;
            buy_fail_q    <= buy_fail_d;
        end
    end

    assign total_money = total_q;
    assign coin_ok     = coin_ok_q;
    assign coin_reject = coin_reject_q;
    assign buy_ok      = buy_ok_q;
    assign buy_fail    = buy_fail_q;

endmodule

// File: doc/coin_accumulator.md
COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required before a button level is accepted (10 ms at 100 MHz).
REQ-002 Parameter MONEY_MAX, default 255, ceiling of the credit total in tenths of a yuan.
REQ-003 CLK100MHZ  input  1  sole clock, all state on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 BTN  input  4  raw coin buttons {BTNC,BTNU,BTNL,BTNR}, asynchronous, bouncing.
REQ-006 buy_req  input  1  single-cycle purchase request from the vending stage.
REQ-007 price  input  8  price of the selected product in tenths; 0 = invalid selection.
REQ-008 total_money  output  8  current credit in tenths.
REQ-009 coin_ok  output  1  one-cycle pulse, coin added.
REQ-010 coin_reject  output  1  one-cycle pulse, coin refused (overflow).
REQ-011 buy_ok  output  1  one-cycle pulse, purchase accepted and price deducted.
REQ-012 buy_fail  output  1  one-cycle pulse, purchase refused.

Function
REQ-013 Each BTN bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per button, a counter SHALL increment while the synchronized level differs from the debounced level, clear when they match, and flip the debounced level when it reaches DEBOUNCE_CYCLES-1.
REQ-015 A coin event SHALL be generated on the 0->1 transition of a debounced level only; release and held levels generate nothing.
REQ-016 Coin values SHALL be BTNR=5, BTNL=10, BTNU=50, BTNC=100 tenths.
REQ-017 Coin events SHALL be latched into a 4-bit pending register and serviced one per cycle, priority BTNC>BTNU>BTNL>BTNR; unserviced bits remain pending.
REQ-018 FSM states IDLE, COIN, BUY: IDLE->BUY if buy_req; else IDLE->COIN if any pending bit; COIN and BUY return to IDLE after one cycle.
REQ-019 buy_req SHALL be captured in IDLE even when coins are pending (buy wins); buy_req arriving in COIN or BUY SHALL be held in a 1-bit request latch and serviced on the next IDLE cycle.
REQ-020 COIN: if total_money+value <= MONEY_MAX (9-bit compare), add value and pulse coin_ok; else leave total unchanged and pulse coin_reject; clear the serviced pending bit in both cases.
REQ-021 BUY: if price != 0 and total_money >= price, subtract price and pulse buy_ok; else total unchanged, pulse buy_fail; price sampled in the BUY cycle.
REQ-022 Output pulses SHALL be registered, asserted the cycle after the COIN/BUY state cycle, never two simultaneously.
REQ-023 Latency from a clean BTN rising edge to coin_ok SHALL be 2+DEBOUNCE_CYCLES+3 cycles when no buy is queued.
REQ-024 total_money SHALL never wrap; it SHALL equal exactly 255 when a coin fills it to MONEY_MAX.

Reset
REQ-025 RST SHALL set total_money=0, all pulses=0, FSM=IDLE, pending=0, buy latch=0, counters=0, synchronizers and debounced levels=0.
REQ-026 RST asserted mid-COIN or mid-BUY SHALL abort without any pulse or total update that cycle.
REQ-027 A button held high through RST release SHALL produce one coin event after debouncing (debounced level restarts at 0).

Verification (DEBOUNCE_CYCLES=4)
REQ-028 BTNL pressed with 3-cycle bounce then held 20 cycles -> exactly one coin_ok, total_money 0->10.
REQ-029 total=250, press BTNL -> coin_reject, total stays 250; press BTNR -> coin_ok, total=255.
REQ-030 total=20, price=15, buy_req -> buy_ok, total=5; repeat buy_req -> buy_fail, total=5; price=0 -> buy_fail.
REQ-031 BTNC and BTNR debounced in same cycle with buy_req, price=5, total=0 -> buy_fail, then coin_ok (+100), then coin_ok (+5), total=105.
REQ-032 RST pulsed during BUY cycle with total=130 -> no buy_ok, total=0 next cycle, FSM IDLE.
